// File: rtl/gnrl_skid_buf_pkg.sv
// gnrl_skid_buf_pkg: shared state encodings for the two-entry skid buffer
package gnrl_skid_buf_pkg;
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;
  typedef enum logic [1:0] {
    EMPTY = ST_EMPTY,
    ONE   = ST_ONE,
    FULL  = ST_FULL
  } skid_state_e;
endpackage

// File: rtl/gnrl_skid_buf_dff_arst.sv
// gnrl_dff_arst: general flop with asynchronous active-low reset to RST_VAL
module gnrl_dff_arst #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
endmodule

// File: rtl/gnrl_skid_buf.sv
// gnrl_skid_buf: two-entry registered valid/ready skid buffer.
// Optional synchronous flush port when GNRL_SKID_FLUSH_EN is defined.
module gnrl_skid_buf
  import gnrl_skid_buf_pkg::*;
#(
  parameter int   WIDTH   = 32,
  parameter logic RST_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef GNRL_SKID_FLUSH_EN
  input  logic             flush,
`endif
  output logic [WIDTH-1:0] out_data
);
  logic [1:0]       state_q;
  skid_state_e      state, state_nxt;
  logic [WIDTH-1:0] main_q, skid_q, main_d, skid_d;
  logic             push, pop, main_en, skid_en;
  assign state     = skid_state_e'(state_q);
  assign in_ready  = ~state_q[1];
  assign out_valid = state_q[0];
  assign out_data  = main_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  always_comb begin
    state_nxt = state;
    main_en   = 1'b0;
    skid_en   = 1'b0;
    case (state)
      EMPTY: begin
        main_en   = push;
        state_nxt = push ? ONE : EMPTY;
      end
      ONE: begin
        main_en   = push & pop;
        skid_en   = push & ~pop;
        state_nxt = (push & ~pop) ? FULL : (pop & ~push) ? EMPTY : ONE;
      end
      FULL: begin
        main_en   = pop;
        state_nxt = pop ? ONE : FULL;
      end
      default: state_nxt = EMPTY;
    endcase
`ifdef GNRL_SKID_FLUSH_EN
    // flush wins over any same-cycle push/pop and leaves payload untouched
    if (flush) begin
      state_nxt = EMPTY;
      main_en   = 1'b0;
      skid_en   = 1'b0;
    end
`endif
    main_d = main_en ? ((state == FULL) ? skid_q : in_data) : main_q;
    skid_d = skid_en ? in_data : skid_q;
  end
  gnrl_dff_arst #(.WIDTH(2), .RST_VAL(ST_EMPTY)) u_state (
    .clk(clk), .rst_n(rst_n), .d(state_nxt), .q(state_q)
  );
  gnrl_dff_arst #(.WIDTH(WIDTH), .RST_VAL({WIDTH{RST_VAL}})) u_main (
    .clk(clk), .rst_n(rst_n), .d(main_d), .q(main_q)
  );
  gnrl_dff_arst #(.WIDTH(WIDTH), .RST_VAL({WIDTH{RST_VAL}})) u_skid (
    .clk(clk), .rst_n(rst_n), .d(skid_d), .q(skid_q)
  );
endmodule

// File: tb/tb_gnrl_skid_buf.sv
// tb_gnrl_skid_buf: directed and scoreboard checks for gnrl_skid_buf.
// Flush vectors run only when GNRL_SKID_FLUSH_EN is defined.
module tb_gnrl_skid_buf;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        flush = 1'b0;
  int          checks = 0;
  int          failures = 0;
  always #5 clk = ~clk;
  gnrl_skid_buf #(.WIDTH(32), .RST_VAL(1'b0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef GNRL_SKID_FLUSH_EN
    .flush(flush),
`endif
    .out_data(out_data)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic iv, input logic [31:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask
  logic [31:0] q[$];
  logic        stall;
  logic [31:0] held;
  initial begin
    #3;
    chk("rst_ov", out_valid, 0);
    chk("rst_ir", in_ready, 1);
    chk("rst_od", out_data, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_ov", out_valid, 0);
    // streaming 0x1..0x10, one per cycle, one cycle latency
    for (int i = 1; i <= 16; i++) begin
      drv(1, i, 1);
      step();
      chk("str_ov", out_valid, 1);
      chk("str_od", out_data, i);
    end
    drv(0, 0, 1);
    step();
    chk("str_end_ov", out_valid, 0);
    // backpressure
    drv(1, 32'hA, 0);
    step();
    chk("bp_a_od", out_data, 32'hA);
    drv(1, 32'hB, 0);
    step();
    chk("bp_full_ir", in_ready, 0);
    chk("bp_full_od", out_data, 32'hA);
    drv(1, 32'hC, 0);
    step();
    chk("bp_c_ir", in_ready, 0);
    chk("bp_c_od", out_data, 32'hA);
    drv(1, 32'hC, 1);
    step();
    chk("bp_b_od", out_data, 32'hB);
    chk("bp_b_ir", in_ready, 1);
    step();
    chk("bp_cc_od", out_data, 32'hC);
    chk("bp_cc_ov", out_valid, 1);
    drv(0, 0, 1);
    step();
    chk("bp_end_ov", out_valid, 0);
    // ONE with simultaneous push and pop
    drv(1, 32'h4, 0);
    step();
    chk("pp_4_od", out_data, 32'h4);
    drv(1, 32'h5, 1);
    step();
    chk("pp_5_od", out_data, 32'h5);
    chk("pp_5_ov", out_valid, 1);
    chk("pp_5_ir", in_ready, 1);
    drv(0, 0, 1);
    step();
    chk("pp_end_ov", out_valid, 0);
    // reset asserted while FULL
    drv(1, 32'h7, 0);
    step();
    drv(1, 32'h8, 0);
    step();
    chk("mr_full_ir", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_ov", out_valid, 0);
    chk("mr_ir", in_ready, 1);
    chk("mr_od", out_data, 0);
    drv(0, 0, 0);
    step();
    rst_n = 1'b1;
    drv(1, 32'h9, 0);
    step();
    chk("mr_post_ov", out_valid, 1);
    chk("mr_post_od", out_data, 32'h9);
    chk("mr_post_ir", in_ready, 1);
    drv(0, 0, 1);
    step();
    chk("mr_end_ov", out_valid, 0);
`ifdef GNRL_SKID_FLUSH_EN
    drv(1, 32'h11, 0);
    step();
    drv(1, 32'h12, 0);
    step();
    chk("fl_full_ir", in_ready, 0);
    drv(1, 32'h13, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_ov", out_valid, 0);
    chk("fl_ir", in_ready, 1);
    drv(0, 0, 1);
    step();
    chk("fl_after_ov", out_valid, 0);
`endif
    // random traffic against a queue model
    stall = 1'b0;
    held  = '0;
    for (int c = 0; c < 10000; c++) begin
      chk("rnd_ov", out_valid, (q.size() != 0) ? 1 : 0);
      chk("rnd_ir", in_ready, (q.size() < 2) ? 1 : 0);
      if (q.size() != 0) chk("rnd_od", out_data, q[0]);
      if (stall) chk("rnd_hold", out_data, held);
      drv($urandom_range(0, 1), $urandom, $urandom_range(0, 1));
      stall = out_valid & ~out_ready;
      held  = out_data;
      if (out_valid && out_ready) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(in_data);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gnrl_skid_buf.md
GNRL_SKID_BUF -- requirements
Module: gnrl_skid_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 SHALL have parameter RST_VAL, default 0, replicated bit value loaded into payload registers on reset.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low; clock is clk.
REQ-005 SHALL have port in_valid  input  1  upstream payload valid.
REQ-006 SHALL have port in_ready  output  1  buffer can accept; driven directly from a flop, with no combinational path from out_ready.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port out_valid  output  1  downstream payload valid; driven directly from a flop.
REQ-009 SHALL have port out_ready  input  1  downstream accepts.
REQ-010 SHALL have port out_data  output  WIDTH  downstream payload; driven directly from the main register.
REQ-011 SHALL have port flush  input  1  synchronous discard of all held entries; present only when GNRL_SKID_FLUSH_EN is defined.

Function
REQ-012 SHALL transfer on the input side when in_valid&in_ready is high, and on the output side when out_valid&out_ready is high, both sampled at the rising edge of clk.
REQ-013 SHALL hold two entries: main (feeds out_*) and skid (overflow); state is EMPTY (0 entries), ONE (main only) or FULL (main+skid).
REQ-014 SHALL drive in_ready=1 in EMPTY and ONE and in_ready=0 in FULL; out_valid=1 in ONE and FULL.
REQ-015 SHALL provide one-cycle latency: data accepted in EMPTY appears on out_data with out_valid=1 in the next cycle.
REQ-016 EMPTY: push -> ONE, main<=in_data; no push -> stay.
REQ-017 ONE: push and pop -> stay ONE, main<=in_data; push only -> FULL, skid<=in_data; pop only -> EMPTY; neither -> stay.
REQ-018 FULL: pop -> ONE, main<=skid; no pop -> stay; in_valid is ignored.
REQ-019 SHALL preserve strict FIFO order and SHALL never drop or duplicate an entry.
REQ-020 SHALL keep out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL leave payload registers unchanged when no write occurs; payload contents in EMPTY are don't-care but SHALL NOT be X after reset.
REQ-022 SHALL sustain one transfer per cycle with in_valid and out_ready held high continuously.

Reset
REQ-023 On rst_n low, SHALL immediately (asynchronously) force state EMPTY, out_valid=0, in_ready=1, and main and skid = {WIDTH{RST_VAL}}.
REQ-024 Reset asserted mid-transfer SHALL discard all held entries; the first cycle after deassertion SHALL behave as EMPTY.

Configuration
REQ-025 With macro GNRL_SKID_FLUSH_EN defined, the flush port SHALL exist, and flush=1 SHALL force EMPTY at the next edge, overriding any simultaneous push or pop; payload registers are unchanged.
REQ-026 Without GNRL_SKID_FLUSH_EN, the flush port and its logic SHALL be absent, and behaviour SHALL be otherwise identical.

Structure
REQ-027 SHALL place state encodings (EMPTY=2'b00, ONE=2'b01, FULL=2'b11) as localparams in the shared gnrl package, not inline.
REQ-028 SHALL implement valid/state flops and payload registers with instances of the existing gnrl_dff_arst general flop; no other sub-module.
REQ-029 Payload registers SHALL use an enable mux in front of gnrl_dff_arst; no clock gating.

Verification
REQ-030 Reset: assert rst_n=0 mid-FULL -> out_valid=0 and in_ready=1 at once; out_data=0 with RST_VAL=0.
REQ-031 Streaming: push 0x1..0x10 with out_ready=1 constantly -> outputs 0x1..0x10 in order, one per cycle, 1-cycle latency.
REQ-032 Backpressure: out_ready=0, push 0xA then 0xB -> FULL, in_ready=0, out_data=0xA stable; 0xC offered is not taken; out_ready=1 -> 0xA, 0xB, then 0xC.
REQ-033 ONE with simultaneous push 0x5 and pop of 0x4 -> state stays ONE, next out_data=0x5.
REQ-034 Flush (macro defined): FULL, then flush=1 with in_valid=1 -> next cycle EMPTY, out_valid=0; the pushed data is discarded.
REQ-035 Random valid/ready for 10k cycles against a scoreboard -> no loss, duplication or reordering, and REQ-020 holds on every cycle.
